csa_product_resolver: RTL and testbench

Sequential carry-propagate stage that consumes the carry-save outputs of the 8x8 Wallace tree multiplier (upper partial sums x[15:5] and y[15:5], resolved low bits z[4:0]) and produces the final 16-bit product. It trades the wide final adder for a CHUNK-bit adder iterated over several cycles. It sits directly downstream of `wallace_8x8`, with valid/ready handshakes on both sides.

---
 rtl/csa_product_resolver.sv | 113 +++++++++++
 tb/tb_csa_product_resolver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/csa_product_resolver.sv
// Final carry-propagate stage for the 8x8 Wallace multiplier: resolves the
// 11-bit carry-save pair x+y CHUNK bits per cycle and presents the 16-bit product.
module csa_product_resolver #(
   parameter int CHUNK = 4
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic [4:0]  z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        cout
);

   localparam int         NCYC     = (11 + CHUNK - 1) / CHUNK;
   // Width of the final, possibly truncated chunk; its carry lands at this bit.
   localparam int         REM      = 11 - (NCYC - 1) * CHUNK;
   localparam logic [4:0] LAST_OFF = 5'((NCYC - 1) * CHUNK);
   localparam logic [4:0] STEP     = 5'(CHUNK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [10:0]      r_x;
   logic [10:0]      r_y;
   logic [10:0]      r_res;
   logic [4:0]       r_z;
   logic [4:0]       r_off;
   logic             r_carry;
   logic             r_cout;

   logic             w_accept;
   logic             w_last;
   logic [CHUNK-1:0] w_xc;
   logic [CHUNK-1:0] w_yc;
   logic [CHUNK:0]   w_sum;
   logic [10:0]      w_ins;

   assign in_ready  = clrn & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_off == LAST_OFF);
   assign out_valid = (r_state == S_DONE);
   assign p         = {r_res, r_z};
   assign cout      = r_cout;

   // Bits above bit 10 shift in as zero, so the last chunk is naturally truncated.
   assign w_xc  = CHUNK'(r_x >> r_off);
   assign w_yc  = CHUNK'(r_y >> r_off);
   assign w_sum = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};
   assign w_ins = 11'({11'b0, w_sum[CHUNK-1:0]} << r_off);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next = S_ADD;
         S_ADD:  if (w_last) w_next = S_DONE;
         S_DONE: begin
            if (w_accept)
               w_next = S_ADD;
            else if (out_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_res   <= '0;
         r_z     <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_off   <= '0;
      end else if (w_accept) begin
         r_res   <= '0;
         r_z     <= z;
         r_carry <= 1'b0;
         r_off   <= '0;
      end else if (r_state == S_ADD) begin
         r_res   <= r_res | w_ins;
         r_carry <= w_sum[CHUNK];
         r_off   <= r_off + STEP;
         if (w_last)
            r_cout <= w_sum[REM];
      end
   end

   // Operand copies need no reset: they are only read after a capture.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_x <= x;
         r_y <= y;
      end
   end

endmodule

// File: tb/tb_csa_product_resolver.sv
// Directed bench for csa_product_resolver at the default CHUNK=4 (3 ADD cycles).
module tb_csa_product_resolver;

   logic        clk = 1'b0;
   logic        clrn;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] x;
   logic [10:0] y;
   logic [4:0]  z;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        cout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   csa_product_resolver dut (
      .clk       (clk),
      .clrn      (clrn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .cout      (cout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Accept one operand from IDLE with out_ready=1 and check the 3-edge latency.
   task automatic run_op(input string tag, input logic [10:0] xi, input logic [10:0] yi,
                         input logic [4:0] zi, input logic [15:0] ep, input logic ec,
                         input bit check_cout);
      x         = xi;
      y         = yi;
      z         = zi;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_rdy_idle"}, 16'(in_ready), 16'h1);
      step();
      in_valid = 1'b0;
      x        = ~xi;
      y        = ~yi;
      z        = ~zi;
      chk({tag, "_rdy_add"}, 16'(in_ready), 16'h0);
      chk({tag, "_vld_add0"}, 16'(out_valid), 16'h0);
      step();
      step();
      chk({tag, "_vld_add2"}, 16'(out_valid), 16'h0);
      step();
      chk({tag, "_vld_done"}, 16'(out_valid), 16'h1);
      chk({tag, "_p"}, p, ep);
      if (check_cout)
         chk({tag, "_cout"}, 16'(cout), 16'(ec));
      step();
      chk({tag, "_vld_idle"}, 16'(out_valid), 16'h0);
   endtask

   logic [7:0]  blist [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'hFF};
   logic [15:0] prod;
   logic [10:0] hi;
   logic [10:0] yv;

   initial begin
      clrn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      y         = '0;
      z         = '0;
      step();
      step();
      chk("rst_vld", 16'(out_valid), 16'h0);
      chk("rst_p", p, 16'h0000);
      chk("rst_cout", 16'(cout), 16'h0);
      chk("rst_rdy", 16'(in_ready), 16'h0);
      clrn = 1'b1;
      #1;
      chk("rst_rdy_rel", 16'(in_ready), 16'h1);

      run_op("basic", 11'h3F8, 11'h001, 5'h01, 16'h7F21, 1'b0, 1'b1);
      run_op("chunkc", 11'h00F, 11'h001, 5'h1F, 16'h021F, 1'b0, 1'b1);
      run_op("ovf", 11'h7F0, 11'h010, 5'h01, 16'h0001, 1'b1, 1'b1);

      // Backpressure, then back-to-back capture on the releasing edge.
      out_ready = 1'b0;
      x         = 11'h3F8;
      y         = 11'h001;
      z         = 5'h01;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("bp_vld", 16'(out_valid), 16'h1);
      chk("bp_p", p, 16'h7F21);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x        = 11'h123;
         y        = 11'h456;
         z        = 5'h0A;
         step();
         chk("bp_hold_vld", 16'(out_valid), 16'h1);
         chk("bp_hold_p", p, 16'h7F21);
         chk("bp_hold_cout", 16'(cout), 16'h0);
         chk("bp_hold_rdy", 16'(in_ready), 16'h0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x         = 11'h7F0;
      y         = 11'h00F;
      z         = 5'h01;
      #1;
      chk("b2b_rdy", 16'(in_ready), 16'h1);
      step();
      in_valid = 1'b0;
      chk("b2b_vld_add", 16'(out_valid), 16'h0);
      step();
      step();
      chk("b2b_vld_add2", 16'(out_valid), 16'h0);
      step();
      chk("b2b_vld", 16'(out_valid), 16'h1);
      chk("b2b_p", p, 16'hFFE1);
      chk("b2b_cout", 16'(cout), 16'h0);
      step();
      chk("b2b_idle", 16'(out_valid), 16'h0);

      // Reset during the second ADD cycle aborts the operation.
      x        = 11'h00F;
      y        = 11'h001;
      z        = 5'h1F;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      clrn = 1'b0;
      step();
      chk("mid_rst_vld", 16'(out_valid), 16'h0);
      chk("mid_rst_p", p, 16'h0000);
      chk("mid_rst_cout", 16'(cout), 16'h0);
      chk("mid_rst_rdy", 16'(in_ready), 16'h0);
      clrn = 1'b1;
      #1;
      chk("mid_rst_rdy_rel", 16'(in_ready), 16'h1);
      run_op("after_rst", 11'h7F0, 11'h010, 5'h01, 16'h0001, 1'b1, 1'b1);

      // Carry-save splits of a*b with a=FF: z holds the low 5 bits, x+y the rest.
      for (int i = 0; i < 8; i++) begin
         prod = 16'h00FF * {8'h00, blist[i]};
         hi   = prod[15:5];
         yv   = {3'b000, blist[i]};
         run_op("wallace", hi - yv, yv, prod[4:0], prod, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
